// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for the five-stage RV32I pipeline.
// Keeps shadow copies of the register metadata held in Execute, Memory and
// Writeback, selects the Execute operand sources, raises the load-use stall
// and branch flush controls, and counts stall/flush events for debug.
module hazard_forward_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             InstrValidD,
  input  logic [4:0]       RS1_D,
  input  logic [4:0]       RS2_D,
  input  logic [4:0]       RD_D,
  input  logic             RegWriteD,
  input  logic             LoadD,
  input  logic             PCSrcE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Execute slot: consumer whose operands are being selected
  logic       e_valid;
  logic [4:0] e_rs1;
  logic [4:0] e_rs2;
  logic [4:0] e_rd;
  logic       e_regwrite;
  logic       e_load;

  // Memory and Writeback slots: potential producers
  logic       m_valid;
  logic [4:0] m_rd;
  logic       m_regwrite;
  logic       w_valid;
  logic [4:0] w_rd;
  logic       w_regwrite;

  logic       m_writes_rs1;
  logic       m_writes_rs2;
  logic       w_writes_rs1;
  logic       w_writes_rs2;
  logic       lw_stall;

  // A producer matches only when it really writes a non-zero register
  always_comb begin
    m_writes_rs1 = m_valid & m_regwrite & (m_rd != 5'd0) & (m_rd == e_rs1);
    m_writes_rs2 = m_valid & m_regwrite & (m_rd != 5'd0) & (m_rd == e_rs2);
    w_writes_rs1 = w_valid & w_regwrite & (w_rd != 5'd0) & (w_rd == e_rs1);
    w_writes_rs2 = w_valid & w_regwrite & (w_rd != 5'd0) & (w_rd == e_rs2);
  end

  // Operand select: Memory stage is younger than Writeback, so it wins
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (e_valid) begin
      if (m_writes_rs1)      ForwardAE = 2'b10;
      else if (w_writes_rs1) ForwardAE = 2'b01;
      if (m_writes_rs2)      ForwardBE = 2'b10;
      else if (w_writes_rs2) ForwardBE = 2'b01;
    end
  end

  // Load-use stall and branch flush; a taken branch squashes the stalled
  // Decode instruction, so it suppresses the stall
  always_comb begin
    lw_stall = InstrValidD & e_valid & e_load & (e_rd != 5'd0) &
               ((e_rd == RS1_D) | (e_rd == RS2_D));
    StallF   = lw_stall & ~PCSrcE;
    StallD   = lw_stall & ~PCSrcE;
    FlushE   = lw_stall | PCSrcE;
    FlushD   = PCSrcE;
  end

  // Advance the shadow pipeline; a flushed Execute slot becomes a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      e_valid    <= 1'b0;
      e_rs1      <= 5'd0;
      e_rs2      <= 5'd0;
      e_rd       <= 5'd0;
      e_regwrite <= 1'b0;
      e_load     <= 1'b0;
      m_valid    <= 1'b0;
      m_rd       <= 5'd0;
      m_regwrite <= 1'b0;
      w_valid    <= 1'b0;
      w_rd       <= 5'd0;
      w_regwrite <= 1'b0;
    end else begin
      w_valid    <= m_valid;
      w_rd       <= m_rd;
      w_regwrite <= m_regwrite;
      m_valid    <= e_valid;
      m_rd       <= e_rd;
      m_regwrite <= e_regwrite;
      if (FlushE) begin
        e_valid    <= 1'b0;
        e_rs1      <= 5'd0;
        e_rs2      <= 5'd0;
        e_rd       <= 5'd0;
        e_regwrite <= 1'b0;
        e_load     <= 1'b0;
      end else begin
        e_valid    <= InstrValidD;
        e_rs1      <= RS1_D;
        e_rs2      <= RS2_D;
        e_rd       <= RD_D;
        e_regwrite <= RegWriteD;
        e_load     <= LoadD;
      end
    end
  end

  // Saturating debug counters for stall cycles and taken-branch flushes
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (StallD && (stall_count != CNT_MAX)) stall_count <= stall_count + CNT_ONE;
      if (PCSrcE && (flush_count != CNT_MAX)) flush_count <= flush_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed and randomized checks of hazard_forward_unit against a
// stage-array reference model.
module tb_hazard_forward_unit;

  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             InstrValidD;
  logic [4:0]       RS1_D, RS2_D, RD_D;
  logic             RegWriteD, LoadD, PCSrcE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, FlushD, FlushE;
  logic [CNT_W-1:0] stall_count, flush_count;

  int tests = 0;
  int failed = 0;

  hazard_forward_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .InstrValidD(InstrValidD),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RD_D(RD_D),
    .RegWriteD(RegWriteD), .LoadD(LoadD), .PCSrcE(PCSrcE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // Reference model: pipe[0] = Execute, pipe[1] = Memory, pipe[2] = Writeback
  typedef struct packed {
    logic       valid;
    logic [4:0] rs1, rs2, rd;
    logic       rw, ld;
  } ent_t;

  ent_t pipe [3];
  int   m_stall;
  int   m_flush;

  function automatic logic [1:0] exp_fwd(input logic [4:0] r);
    if (!pipe[0].valid) return 2'b00;
    for (int s = 1; s <= 2; s++)
      if (pipe[s].valid && pipe[s].rw && r != 5'd0 && pipe[s].rd == r)
        return (s == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic logic exp_lw();
    return InstrValidD && pipe[0].valid && pipe[0].ld && pipe[0].rd != 5'd0 &&
           (pipe[0].rd == RS1_D || pipe[0].rd == RS2_D);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_d(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic ld,
                       input logic br);
    InstrValidD = v; RS1_D = rs1; RS2_D = rs2; RD_D = rd;
    RegWriteD = rw; LoadD = ld; PCSrcE = br;
    #1;
  endtask

  task automatic check_model(input string tag);
    logic lw, br;
    lw = exp_lw();
    br = PCSrcE;
    chk({tag, ".fwdA"}, 32'(ForwardAE), 32'(exp_fwd(pipe[0].rs1)));
    chk({tag, ".fwdB"}, 32'(ForwardBE), 32'(exp_fwd(pipe[0].rs2)));
    chk({tag, ".stallF"}, 32'(StallF), 32'(lw && !br));
    chk({tag, ".stallD"}, 32'(StallD), 32'(lw && !br));
    chk({tag, ".flushD"}, 32'(FlushD), 32'(br));
    chk({tag, ".flushE"}, 32'(FlushE), 32'(lw || br));
    chk({tag, ".stall_cnt"}, 32'(stall_count), 32'(m_stall));
    chk({tag, ".flush_cnt"}, 32'(flush_count), 32'(m_flush));
  endtask

  // Update the model from the current inputs, then cross one rising edge
  task automatic advance();
    logic lw, br;
    lw = exp_lw();
    br = PCSrcE;
    if (rst) begin
      for (int s = 0; s < 3; s++) pipe[s] = '0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (lw || br) pipe[0] = '0;
      else pipe[0] = '{valid: InstrValidD, rs1: RS1_D, rs2: RS2_D, rd: RD_D,
                      rw: RegWriteD, ld: LoadD};
      if (lw && !br && m_stall < CNT_MAX) m_stall++;
      if (br && m_flush < CNT_MAX) m_flush++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input string tag);
    check_model(tag);
    advance();
  endtask

  int s_before;
  int f_before;

  initial begin
    for (int s = 0; s < 3; s++) pipe[s] = '0;
    m_stall = 0;
    m_flush = 0;
    rst = 1'b1;
    set_d(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Reset with arbitrary Decode traffic
    set_d(1'b1, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0);
    advance();
    set_d(1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)), 1'b1, 1'b1, 1'b0);
    step("reset");
    rst = 1'b0;
    set_d(1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    chk("rst_fwdA", 32'(ForwardAE), 32'd0);
    chk("rst_fwdB", 32'(ForwardBE), 32'd0);
    chk("rst_stall_cnt", 32'(stall_count), 32'd0);
    chk("rst_flush_cnt", 32'(flush_count), 32'd0);
    step("idle");
    step("idle2");

    // ALU chain, adjacent: producer in M when consumer in E
    set_d(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0); step("addi_x5");
    set_d(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0); step("add_x6");
    set_d(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("alu_adj_fwdA", 32'(ForwardAE), 32'h2);
    chk("alu_adj_fwdB", 32'(ForwardBE), 32'h2);
    step("alu_adj");

    // ALU chain with one unrelated instruction between
    set_d(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0); step("addi_x5b");
    set_d(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0); step("unrelated");
    set_d(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0); step("add_x6b");
    set_d(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("alu_gap_fwdA", 32'(ForwardAE), 32'h1);
    chk("alu_gap_fwdB", 32'(ForwardBE), 32'h1);
    step("alu_gap");
    step("drain");

    // Load-use: one stall cycle, then forward from Writeback
    set_d(1'b1, 5'd2, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0); step("load_x7");
    set_d(1'b1, 5'd3, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0);
    chk("lu_stallF", 32'(StallF), 32'h1);
    chk("lu_stallD", 32'(StallD), 32'h1);
    chk("lu_flushE", 32'(FlushE), 32'h1);
    chk("lu_flushD", 32'(FlushD), 32'h0);
    step("lu_stall");
    chk("lu_nostall", 32'(StallD), 32'h0);
    chk("lu_stall_cnt", 32'(stall_count), 32'h1);
    step("lu_bubble");
    set_d(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("lu_fwdA", 32'(ForwardAE), 32'h0);
    chk("lu_fwdB", 32'(ForwardBE), 32'h1);
    step("lu_consume");
    step("drain2");

    // x0 producer (a load to x0) and a non-writing producer
    set_d(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0); step("ld_x0");
    set_d(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0);
    chk("x0_nostall", 32'(StallD), 32'h0);
    step("use_x0");
    set_d(1'b1, 5'd1, 5'd1, 5'd3, 1'b0, 1'b0, 1'b0);
    chk("x0_fwdA", 32'(ForwardAE), 32'h0);
    chk("x0_fwdB", 32'(ForwardBE), 32'h0);
    step("nowr_x3");
    set_d(1'b1, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0); step("use_x3");
    set_d(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("nowr_fwdA", 32'(ForwardAE), 32'h0);
    chk("nowr_fwdB", 32'(ForwardBE), 32'h0);
    step("nowr_chk");
    step("drain3");

    // Taken branch coinciding with a load-use condition
    set_d(1'b1, 5'd2, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0); step("load_x7b");
    set_d(1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b0, 1'b1);
    chk("br_stallD", 32'(StallD), 32'h0);
    chk("br_flushD", 32'(FlushD), 32'h1);
    chk("br_flushE", 32'(FlushE), 32'h1);
    s_before = int'(stall_count);
    f_before = int'(flush_count);
    step("br_lu");
    set_d(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("br_flush_inc", 32'(flush_count), 32'(f_before + 1));
    chk("br_stall_same", 32'(stall_count), 32'(s_before));
    step("br_after");

    // Five stall cycles: each reload of a dependent load re-arms the hazard
    set_d(1'b1, 5'd7, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step("sat_run");
    chk("sat_stall_cnt", 32'(stall_count), 32'(CNT_MAX));
    step("sat_extra");

    // Reset in the middle of a stall
    while (!StallD && tests < 100000) step("find_stall");
    chk("pre_rst_stall", 32'(StallD), 32'h1);
    rst = 1'b1;
    step("mid_rst");
    rst = 1'b0;
    set_d(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_cnt", 32'(stall_count), 32'h0);
    chk("mid_rst_fwdA", 32'(ForwardAE), 32'h0);
    chk("mid_rst_fwdB", 32'(ForwardBE), 32'h0);
    step("post_rst");

    // Randomized traffic with small register range to provoke hazards
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      set_d(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 7) == 0));
      step("rand");
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
